// File: rtl/median_filter_seq.sv
`default_nettype none
// ============================================================================
// Module      : median_filter_seq
// Description : Sequencer for a 3x3 median filter over a frame held in an
//               external pixel memory. Pixels are visited in raster order.
//               Interior pixels have their 3x3 neighbourhood fetched and
//               offered to an external median core. The returned median is
//               written to the result memory. Border pixels are copied
//               unchanged.
//
// Ports       : CLK, RST                 clock, synchronous active-high reset
//               start_i, width_i,        frame start pulse and dimensions
//               height_i
//               busy_o, done_o           frame in progress / sticky complete
//               rd_en_o, rd_addr_o,      source memory read port
//               rd_data_i                (data returns one cycle after rd_en_o)
//               win_valid_o, win_data_o, window handshake to the median core
//               win_ready_i              (p0 in LSBs, row-major to p8)
//               med_valid_i, med_data_i  median result from the core
//               wr_en_o, wr_addr_o,      result memory write port
//               wr_data_o
// Revision    : 1.0 - initial release
// ============================================================================
module median_filter_seq #(
    parameter int ADDR_W = 18,
    parameter int PIX_W  = 8,
    parameter int DIM_W  = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start_i,
    input  logic [DIM_W-1:0]     width_i,
    input  logic [DIM_W-1:0]     height_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [PIX_W-1:0]     rd_data_i,
    output logic                 win_valid_o,
    output logic [9*PIX_W-1:0]   win_data_o,
    input  logic                 win_ready_i,
    input  logic                 med_valid_i,
    input  logic [PIX_W-1:0]     med_data_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [PIX_W-1:0]     wr_data_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_LAST = 3'd2,
        ISSUE     = 3'd3,
        WAIT_MED  = 3'd4,
        WRITE     = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t               state_q;
    logic [DIM_W-1:0]     width_q;
    logic [DIM_W-1:0]     height_q;
    logic [DIM_W-1:0]     row_q;
    logic [DIM_W-1:0]     col_q;
    logic [ADDR_W-1:0]    row_base_q;
    logic [ADDR_W-1:0]    centre_q;
    logic                 interior_q;
    logic [3:0]           fetch_idx_q;
    logic [3:0]           cap_idx_q;
    logic                 rd_v_q;
    logic [9*PIX_W-1:0]   win_q;

    logic                 busy_q;
    logic                 done_q;
    logic                 rd_en_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic                 win_valid_q;
    logic                 wr_en_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [PIX_W-1:0]     wr_data_q;

    logic [DIM_W-1:0]     row_d;
    logic [DIM_W-1:0]     col_d;
    logic [ADDR_W-1:0]    row_base_d;
    logic [ADDR_W-1:0]    centre_d;
    logic                 interior_d;
    logic [ADDR_W-1:0]    first_addr_d;
    logic [ADDR_W-1:0]    fetch_step_d;

    logic [ADDR_W-1:0]    w_ext;
    logic                 empty;
    logic                 last_col;
    logic                 last_row;

    // A pixel needs a full window only when it has a neighbour on every
    // side; frames narrower or shorter than 3 therefore have no interior.
    function automatic logic is_interior(
        input logic [DIM_W-1:0] r,
        input logic [DIM_W-1:0] c,
        input logic [DIM_W-1:0] w,
        input logic [DIM_W-1:0] h
    );
        return (w >= DIM_W'(3)) && (h >= DIM_W'(3)) &&
               (r != '0) && (c != '0) &&
               (r != h - DIM_W'(1)) && (c != w - DIM_W'(1));
    endfunction

    assign w_ext    = ADDR_W'(width_q);
    assign empty    = (width_q == '0) || (height_q == '0);
    assign last_col = (col_q == width_q - DIM_W'(1));
    assign last_row = (row_q == height_q - DIM_W'(1));

    // Next pixel position. The row base is accumulated by adding the width
    // once per row, so no multiplier is needed for row*W + col.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q + DIM_W'(1);
        row_base_d   = row_base_q;
        centre_d     = centre_q + ADDR_W'(1);
        if (last_col) begin
            row_d      = row_q + DIM_W'(1);
            col_d      = '0;
            row_base_d = row_base_q + w_ext;
            centre_d   = row_base_q + w_ext;
        end
        interior_d   = is_interior(row_d, col_d, width_q, height_q);
        first_addr_d = interior_d ? (centre_d - w_ext - ADDR_W'(1)) : centre_d;
    end

    // Walk p0..p8: step by one within a window row, and jump to the start of
    // the next window row after p2 and p5.
    always_comb begin
        fetch_step_d = rd_addr_q + ADDR_W'(1);
        if ((fetch_idx_q == 4'd2) || (fetch_idx_q == 4'd5)) begin
            fetch_step_d = rd_addr_q + w_ext - ADDR_W'(2);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            centre_q    <= '0;
            interior_q  <= 1'b0;
            fetch_idx_q <= '0;
            cap_idx_q   <= '0;
            rd_v_q      <= 1'b0;
            win_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            win_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            // Read data arrives one cycle after the strobe; slot it into the
            // window in fetch order.
            rd_v_q <= rd_en_q;
            if (rd_v_q && (cap_idx_q < 4'd9)) begin
                win_q[int'(cap_idx_q)*PIX_W +: PIX_W] <= rd_data_i;
                cap_idx_q <= cap_idx_q + 4'd1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        width_q     <= width_i;
                        height_q    <= height_i;
                        row_q       <= '0;
                        col_q       <= '0;
                        row_base_q  <= '0;
                        centre_q    <= '0;
                        interior_q  <= 1'b0;
                        fetch_idx_q <= '0;
                        cap_idx_q   <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        rd_addr_q   <= '0;
                        // An empty frame spends one cycle in FETCH with no
                        // read, then finishes.
                        rd_en_q     <= (width_i != '0) && (height_i != '0);
                        state_q     <= FETCH;
                    end
                end

                FETCH: begin
                    if (empty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (!interior_q || (fetch_idx_q == 4'd8)) begin
                        rd_en_q <= 1'b0;
                        state_q <= WAIT_LAST;
                    end else begin
                        fetch_idx_q <= fetch_idx_q + 4'd1;
                        rd_addr_q   <= fetch_step_d;
                    end
                end

                WAIT_LAST: begin
                    // The last requested pixel is on rd_data_i this cycle.
                    if (interior_q) begin
                        win_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= centre_q;
                        wr_data_q <= rd_data_i;
                        state_q   <= WRITE;
                    end
                end

                ISSUE: begin
                    if (win_ready_i) begin
                        win_valid_q <= 1'b0;
                        state_q     <= WAIT_MED;
                    end
                end

                WAIT_MED: begin
                    if (med_valid_i) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= centre_q;
                        wr_data_q <= med_data_i;
                        state_q   <= WRITE;
                    end
                end

                WRITE: begin
                    wr_en_q <= 1'b0;
                    if (last_row && last_col) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        row_q       <= row_d;
                        col_q       <= col_d;
                        row_base_q  <= row_base_d;
                        centre_q    <= centre_d;
                        interior_q  <= interior_d;
                        fetch_idx_q <= '0;
                        cap_idx_q   <= '0;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= first_addr_d;
                        state_q     <= FETCH;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign win_valid_o = win_valid_q;
    assign win_data_o  = win_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_median_filter_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_median_filter_seq
// Description : Scoreboard bench for median_filter_seq. Each frame start
//               pushes the expected read addresses, windows and writes; a
//               monitor on the falling edge plays the memory and median core
//               and pops/compares whenever the DUT presents a transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_filter_seq;

    localparam int ADDR_W = 18;
    localparam int PIX_W  = 8;
    localparam int DIM_W  = 10;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                start_i = 1'b0;
    logic [DIM_W-1:0]    width_i = '0;
    logic [DIM_W-1:0]    height_i = '0;
    logic                busy_o;
    logic                done_o;
    logic                rd_en_o;
    logic [ADDR_W-1:0]   rd_addr_o;
    logic [PIX_W-1:0]    rd_data_i = '0;
    logic                win_valid_o;
    logic [9*PIX_W-1:0]  win_data_o;
    logic                win_ready_i = 1'b0;
    logic                med_valid_i = 1'b0;
    logic [PIX_W-1:0]    med_data_i = '0;
    logic                wr_en_o;
    logic [ADDR_W-1:0]   wr_addr_o;
    logic [PIX_W-1:0]    wr_data_o;

    median_filter_seq #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i),
        .width_i(width_i), .height_i(height_i),
        .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .win_valid_o(win_valid_o), .win_data_o(win_data_o), .win_ready_i(win_ready_i),
        .med_valid_i(med_valid_i), .med_data_i(med_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]        mem [0:255];
    logic [ADDR_W-1:0] exp_rd [$];
    logic [71:0]       exp_win [$];
    logic [25:0]       exp_wr [$];

    // monitor / model state
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_pend_addr = '0;
    logic        prev_rd = 1'b0;
    logic        prev_win = 1'b0;
    logic        win_in_pix = 1'b0;
    logic        wr_in_frame = 1'b0;
    int          first_rd_cyc = 0;
    int          last_wr_cyc = 0;
    int          med_cyc = 0;
    int          med_cnt = 0;
    logic [7:0]  med_val = '0;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          wr_cnt = 0;
    int          pix_cnt = 0;
    logic [71:0] win_seen = '0;
    logic [71:0] mw;
    logic [25:0] me;
    logic [ADDR_W-1:0] ma;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event at cycle %0d, expected none", name, cyc);
    endtask

    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] v [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) v[i] = w[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[4];
    endfunction

    // Reference behaviour of a whole frame.
    task automatic gen_frame(input int w, input int h);
        logic [71:0] win;
        int cen, a, k;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                cen = r*w + c;
                if (w >= 3 && h >= 3 && r > 0 && r < h-1 && c > 0 && c < w-1) begin
                    win = '0;
                    k = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            a = cen + dr*w + dc;
                            exp_rd.push_back(ADDR_W'(a));
                            win[k*8 +: 8] = mem[a];
                            k++;
                        end
                    end
                    exp_win.push_back(win);
                    exp_wr.push_back({ADDR_W'(cen), median9(win)});
                end else begin
                    exp_rd.push_back(ADDR_W'(cen));
                    exp_wr.push_back({ADDR_W'(cen), mem[cen]});
                end
            end
        end
    endtask

    // Memory, median core and scoreboard monitor. Inputs set here belong to
    // the cycle whose outputs are being observed.
    always @(negedge CLK) begin
        med_valid_i = 1'b0;
        med_data_i  = '0;
        rd_data_i   = rd_pend ? mem[rd_pend_addr] : 8'hA5;
        rd_pend      = rd_en_o;
        rd_pend_addr = rd_addr_o[7:0];

        if (!busy_o && (rd_en_o || win_valid_o || wr_en_o)) fail_evt("strobe_idle");

        if (med_cnt > 0) begin
            med_cnt--;
            if (med_cnt == 0) begin
                med_valid_i = 1'b1;
                med_data_i  = med_val;
                med_cyc     = cyc;
            end
        end

        if (rd_en_o) begin
            if (!prev_rd) begin
                if (wr_in_frame) check("next_rd_gap", cyc - last_wr_cyc, 1);
                first_rd_cyc = cyc;
                win_in_pix   = 1'b0;
                pix_cnt++;
            end
            if (exp_rd.size() == 0) fail_evt("rd_extra");
            else begin
                ma = exp_rd.pop_front();
                check("rd_addr", rd_addr_o, ma);
            end
        end
        prev_rd = rd_en_o;

        if (win_valid_o) begin
            if (!prev_win) begin
                check("win_latency", cyc - first_rd_cyc, 10);
                win_in_pix = 1'b1;
            end
            if (exp_win.size() == 0) fail_evt("win_extra");
            else check("win_data", win_data_o, exp_win[0]);
            if (stall_left > 0) begin
                win_ready_i = 1'b0;
                stall_left--;
                stall_seen++;
                // stray result while the window is still pending
                med_valid_i = 1'b1;
                med_data_i  = 8'hEE;
            end else begin
                win_ready_i = 1'b1;
                mw = win_data_o;
                win_seen = mw;
                if (exp_win.size() != 0) void'(exp_win.pop_front());
                med_val = median9(mw);
                med_cnt = 2;
            end
        end else begin
            win_ready_i = 1'b0;
        end
        prev_win = win_valid_o;

        if (wr_en_o) begin
            if (win_in_pix) check("wr_after_med", cyc - med_cyc, 1);
            else check("border_wr_latency", cyc - first_rd_cyc, 2);
            if (exp_wr.size() == 0) fail_evt("wr_extra");
            else begin
                me = exp_wr.pop_front();
                check("wr_addr", wr_addr_o, me[25:8]);
                check("wr_data", wr_data_o, me[7:0]);
            end
            last_wr_cyc = cyc;
            wr_in_frame = 1'b1;
            wr_cnt++;
        end
    end

    task automatic start_frame(input int w, input int h);
        gen_frame(w, h);
        wr_cnt = 0;
        wr_in_frame = 1'b0;
        pix_cnt = 0;
        width_i = DIM_W'(w);
        height_i = DIM_W'(h);
        start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_done_clear", done_o, 0);
    endtask

    task automatic wait_done(input bit nonempty);
        int n = 0;
        while (!done_o && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("done_reached", done_o, 1);
        if (done_o && nonempty) check("done_after_last_wr", cyc - last_wr_cyc, 1);
        check("busy_at_done", busy_o, 0);
        check("rd_left", exp_rd.size(), 0);
        check("win_left", exp_win.size(), 0);
        check("wr_left", exp_wr.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy_o, done_o, rd_en_o, rd_addr_o, win_valid_o,
                     wr_en_o, wr_addr_o, wr_data_o}, '0);
        check({name, "_win"}, win_data_o, '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        // 3x3 image 1..9: one interior pixel, window 1..9, median 5 at addr 4
        for (int a = 0; a < 256; a++) mem[a] = 8'(a + 1);
        start_frame(3, 3);
        wait_done(1);
        check("t1_writes", wr_cnt, 9);
        check("t1_window", win_seen, 72'h09_08_07_06_05_04_03_02_01);

        // 2x5: every pixel is border, copies only
        for (int a = 0; a < 256; a++) mem[a] = 8'(a*37 + 11);
        start_frame(2, 5);
        wait_done(1);
        check("t2_writes", wr_cnt, 10);

        // zero width: no traffic, done two cycles after start
        start_frame(0, 7);
        @(negedge CLK);
        check("t3_done_2cyc", done_o, 1);
        check("t3_busy", busy_o, 0);
        check("t3_writes", wr_cnt, 0);

        // 4x4 with the first window stalled for 5 cycles
        for (int a = 0; a < 256; a++) mem[a] = 8'(a*29 + 7);
        stall_seen = 0;
        stall_left = 5;
        start_frame(4, 4);
        wait_done(1);
        check("t4_stall_cycles", stall_seen, 5);
        check("t4_writes", wr_cnt, 16);

        // 5x5 with reset on the third pixel, then a clean rerun
        for (int a = 0; a < 256; a++) mem[a] = 8'(a*53 + 101);
        start_frame(5, 5);
        n = 0;
        while (pix_cnt < 3 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("t5_third_pixel", pix_cnt >= 3, 1);
        RST = 1'b1;
        @(negedge CLK);
        check_all_zero("t5_midframe_reset");
        RST = 1'b0;
        exp_rd.delete();
        exp_win.delete();
        exp_wr.delete();
        @(negedge CLK);
        med_cnt = 0;
        check("t5_idle_after_reset", {busy_o, done_o}, 2'b00);
        start_frame(5, 5);
        wait_done(1);
        check("t5_writes", wr_cnt, 25);

        // 6x5 with a second start mid-frame that must be ignored
        for (int a = 0; a < 256; a++) mem[a] = 8'(a*71 + 13);
        start_frame(6, 5);
        repeat (40) @(negedge CLK);
        width_i = DIM_W'(3);
        height_i = DIM_W'(3);
        start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        check("t6_busy_after_restart", busy_o, 1);
        wait_done(1);
        check("t6_writes", wr_cnt, 30);
        repeat (3) @(negedge CLK);
        check("t6_done_sticky", done_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/median_filter_seq.md
MEDIAN_FILTER_SEQ -- requirements
Module: median_filter_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, pixel-memory address width.
REQ-002 SHALL have parameter PIX_W, default 8, pixel width.
REQ-003 SHALL have parameter DIM_W, default 10, image width/height field width.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  one-cycle start pulse.
REQ-007 SHALL have port width_i  input  DIM_W  image width; sampled on accepted start.
REQ-008 SHALL have port height_i  input  DIM_W  image height; sampled on accepted start.
REQ-009 SHALL have port busy_o  output  1  frame in progress.
REQ-010 SHALL have port done_o  output  1  sticky frame-complete flag.
REQ-011 SHALL have port rd_en_o  output  1  source-memory read strobe.
REQ-012 SHALL have port rd_addr_o  output  ADDR_W  source read address.
REQ-013 SHALL have port rd_data_i  input  PIX_W  read data, valid the cycle after rd_en_o.
REQ-014 SHALL have port win_valid_o  output  1  3x3 window offered to median core.
REQ-015 SHALL have port win_data_o  output  9*PIX_W  window, p0 (top-left) in LSBs, row-major to p8 (bottom-right).
REQ-016 SHALL have port win_ready_i  input  1  median core accepts window.
REQ-017 SHALL have port med_valid_i  input  1  median result valid.
REQ-018 SHALL have port med_data_i  input  PIX_W  median result.
REQ-019 SHALL have port wr_en_o  output  1  result-memory write strobe.
REQ-020 SHALL have port wr_addr_o  output  ADDR_W  result write address.
REQ-021 SHALL have port wr_data_o  output  PIX_W  result write data.

Function
REQ-022 SHALL implement FSM states IDLE, FETCH, WAIT_LAST, ISSUE, WAIT_MED, WRITE, DONE.
REQ-023 SHALL accept start_i only in IDLE or DONE; start while busy is ignored; acceptance clears done_o and sets busy_o next cycle.
REQ-024 SHALL process pixels in raster order, address = row*W + col, 0..W*H-1, via row-base accumulator (row_base += W per row), no multiplier.
REQ-025 Interior pixel (1<=row<=H-2, 1<=col<=W-2): FETCH issues 9 reads on 9 consecutive cycles, addresses p0..p8 = base±W±1 row-major.
REQ-026 Interior pixel: win_valid_o SHALL assert exactly 10 cycles after its first rd_en_o, holding win_data_o stable until win_valid_o & win_ready_i.
REQ-027 After handshake SHALL wait in WAIT_MED; med_valid_i outside WAIT_MED ignored.
REQ-028 wr_en_o SHALL pulse one cycle, the cycle after med_valid_i is sampled, with wr_data_o = med_data_i, wr_addr_o = centre address.
REQ-029 Border pixel (row 0, row H-1, col 0, col W-1): single read of centre; wr_en_o two cycles after that rd_en_o, data copied unchanged; no window issued.
REQ-030 If W<3 or H<3 every pixel SHALL be treated as border.
REQ-031 If W=0 or H=0: no reads or writes; done_o asserts two cycles after start accepted.
REQ-032 Next pixel's first rd_en_o SHALL occur the cycle after the previous pixel's wr_en_o.
REQ-033 After final write, busy_o SHALL drop and done_o assert on the next cycle; done_o holds until next accepted start or RST.
REQ-034 rd_en_o, win_valid_o, wr_en_o SHALL never be asserted in IDLE or DONE.

Reset
REQ-035 RST SHALL force state IDLE and all outputs to 0 (busy_o, done_o, strobes, addresses, data, win_data_o) on the next edge, including mid-frame; no pending write completes.

Verification
REQ-036 3x3 image 1..9, core model returns true median -> reads for centre 0,1,...,8, win_data_o p0..p8 = 1..9, write addr 4 data 5; 9 writes total, others copy, done_o.
REQ-037 W=2, H=5 -> 10 writes addr 0..9 copying input, win_valid_o never asserted, done_o.
REQ-038 W=0, H=7 -> no rd_en_o/wr_en_o, done_o high two cycles after start.
REQ-039 win_ready_i held low 5 cycles on first window -> win_valid_o high and win_data_o unchanged all 5 cycles; single write after release.
REQ-040 RST at 3rd pixel of 5x5 frame -> all outputs 0 next cycle; new start completes 25 writes, addr 0..24.
REQ-041 430x554 frame, start pulsed again mid-frame -> second start ignored; 238220 writes, addr 0..238219 in order, done_o once.
